// File: rtl/program_dumper_if.sv
// rtl/program_dumper_if.sv - RAM read port and dumped-word stream between program_dumper and its neighbours
interface program_dumper_if #(
  parameter int WORD_SIZE     = 16,
  parameter int MEM_ADDR_SIZE = 8
);
  logic [MEM_ADDR_SIZE-1:0] mem_addr;
  logic                     mem_read;
  logic [WORD_SIZE-1:0]     mem_read_data;
  logic [WORD_SIZE-1:0]     out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;

  modport master (
    output mem_addr, mem_read, out_data, out_valid, out_last,
    input  mem_read_data, out_ready
  );

  modport slave (
    input  mem_addr, mem_read, out_data, out_valid, out_last,
    output mem_read_data, out_ready
  );
endinterface

// File: rtl/program_dumper.sv
// rtl/program_dumper.sv - streams a RAM region out word by word while start_dump is held
module program_dumper #(
  parameter int WORD_SIZE     = 16,
  parameter int MEM_ADDR_SIZE = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start_dump,
  input  logic [MEM_ADDR_SIZE-1:0] base_addr,
  input  logic [MEM_ADDR_SIZE:0]   word_count,
  program_dumper_if.master         bus,
  output logic                     dump_busy,
  output logic                     dump_complete
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [MEM_ADDR_SIZE-1:0] ADDR_ONE  = MEM_ADDR_SIZE'(1);
  localparam logic [MEM_ADDR_SIZE:0]   COUNT_ONE = (MEM_ADDR_SIZE+1)'(1);

  state_t                   state;
  logic [MEM_ADDR_SIZE-1:0] addr;
  logic [MEM_ADDR_SIZE:0]   remaining;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_dump) begin
            addr      <= base_addr;
            remaining <= word_count;
            state     <= (word_count != '0) ? READ : DONE;
          end
        end
        READ: begin
          state <= start_dump ? CAPTURE : IDLE;
        end
        CAPTURE: begin
          if (!start_dump) begin
            state <= IDLE;
          end else begin
            bus.out_data <= bus.mem_read_data;
            bus.out_last <= (remaining == COUNT_ONE);
            state        <= SEND;
          end
        end
        SEND: begin
          // An abort wins over a simultaneous out_ready, so the word is not consumed.
          if (!start_dump) begin
            state <= IDLE;
          end else if (bus.out_ready) begin
            remaining <= remaining - COUNT_ONE;
            addr      <= addr + ADDR_ONE;
            state     <= bus.out_last ? DONE : READ;
          end
        end
        DONE: begin
          if (!start_dump) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = addr;
  assign bus.mem_read  = (state == READ);
  assign bus.out_valid = (state == SEND);
  assign dump_busy     = (state == READ) || (state == CAPTURE) || (state == SEND);
  assign dump_complete = (state == DONE);

endmodule

// File: tb/tb_program_dumper.sv
// tb/tb_program_dumper.sv - bench for program_dumper with a RAM model and an expected-word queue
module tb_program_dumper;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_dump;
  logic [7:0] base_addr;
  logic [8:0] word_count;
  logic       dump_busy;
  logic       dump_complete;

  program_dumper_if #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8)) bus ();

  program_dumper #(.WORD_SIZE(16), .MEM_ADDR_SIZE(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .start_dump    (start_dump),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .bus           (bus),
    .dump_busy     (dump_busy),
    .dump_complete (dump_complete)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [256];
  exp_t        exp_q[$];
  logic [7:0]  rd_addr[$];
  logic [15:0] rx[$];
  int          reads, valid_cnt, words_done, stall_left;
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // RAM returns data the cycle after mem_read.
  always @(posedge clock) begin
    if (bus.mem_read) bus.mem_read_data <= mem[bus.mem_addr];
  end

  // Every word presented must be the next region word, in order, with last only on the final one.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.mem_read) begin
        reads++;
        rd_addr.push_back(bus.mem_addr);
        if (exp_q.size() == 0) check("mem_read_without_pending_word", {31'd0, bus.mem_read}, 32'd0);
        else check("mem_addr", {24'd0, bus.mem_addr}, {24'd0, exp_q[0].addr});
      end
      if (bus.out_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("out_valid_without_pending_word", {31'd0, bus.out_valid}, 32'd0);
        end else begin
          check("out_data", {16'd0, bus.out_data}, {16'd0, exp_q[0].data});
          check("out_last", {31'd0, bus.out_last}, {31'd0, exp_q[0].last});
          if (bus.out_ready && start_dump) begin
            rx.push_back(bus.out_data);
            void'(exp_q.pop_front());
            words_done++;
          end
        end
      end
    end
  end

  task automatic expect_region(input logic [7:0] base, input logic [8:0] count);
    exp_q.delete(); rd_addr.delete(); rx.delete();
    reads = 0; valid_cnt = 0; words_done = 0;
    for (int i = 0; i < int'(count); i++) begin
      exp_t e;
      e.addr = base + 8'(i);
      e.data = mem[e.addr];
      e.last = (i == int'(count) - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_dump(input logic [7:0] base, input logic [8:0] count,
                          input int stall_word, input int stall_n, output int cycles);
    expect_region(base, count);
    base_addr  = base;
    word_count = count;
    bus.out_ready = 1'b1;
    start_dump = 1'b1;
    stall_left = stall_n;
    step();
    cycles = 0;
    while (!dump_complete && cycles < 2000) begin
      step();
      cycles++;
      if (bus.out_valid && words_done == stall_word && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
    check("dump_complete_reached", {31'd0, dump_complete}, 32'd1);
    check("words_outstanding", exp_q.size(), 32'd0);
    start_dump = 1'b0;
    step();
    check("dump_complete_released", {31'd0, dump_complete}, 32'd0);
  endtask

  initial begin
    int k;
    for (int a = 0; a < 256; a++) mem[a] = {8'(a), ~8'(a)};
    mem[8'h10] = 16'hA001; mem[8'h11] = 16'hA002;
    mem[8'h12] = 16'hA003; mem[8'h13] = 16'hA004;
    bus.mem_read_data = '0;
    reset = 1'b1; start_dump = 1'b0; base_addr = '0; word_count = '0; bus.out_ready = 1'b0;
    step(); step();
    check("rst_mem_addr",      {24'd0, bus.mem_addr}, 32'd0);
    check("rst_mem_read",      {31'd0, bus.mem_read}, 32'd0);
    check("rst_out_data",      {16'd0, bus.out_data}, 32'd0);
    check("rst_out_valid",     {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_last",      {31'd0, bus.out_last}, 32'd0);
    check("rst_dump_busy",     {31'd0, dump_busy}, 32'd0);
    check("rst_dump_complete", {31'd0, dump_complete}, 32'd0);
    reset = 1'b0;
    step();

    run_dump(8'h10, 9'd4, -1, 0, cyc);
    check("basic_cycles", cyc, 32'd12);
    check("basic_reads", reads, 32'd4);
    check("basic_words", rx.size(), 32'd4);
    check("basic_first", {16'd0, rx[0]}, 32'hA001);
    check("basic_final", {16'd0, rx[3]}, 32'hA004);
    check("basic_valid_cycles", valid_cnt, 32'd4);

    run_dump(8'h10, 9'd4, 1, 5, cyc);
    check("bp_cycles", cyc, 32'd17);
    check("bp_reads", reads, 32'd4);
    check("bp_valid_cycles", valid_cnt, 32'd9);
    check("bp_word2", {16'd0, rx[1]}, 32'hA002);

    run_dump(8'hFE, 9'd3, -1, 0, cyc);
    check("wrap_cycles", cyc, 32'd9);
    check("wrap_addr0", {24'd0, rd_addr[0]}, 32'hFE);
    check("wrap_addr1", {24'd0, rd_addr[1]}, 32'hFF);
    check("wrap_addr2", {24'd0, rd_addr[2]}, 32'h00);

    run_dump(8'h00, 9'd256, -1, 0, cyc);
    check("full_cycles", cyc, 32'd768);
    check("full_words", rx.size(), 32'd256);
    check("full_reads", reads, 32'd256);
    check("full_last_addr", {24'd0, rd_addr[255]}, 32'hFF);
    check("full_last_data", {16'd0, rx[255]}, 32'hFF00);

    run_dump(8'h40, 9'd0, -1, 0, cyc);
    check("zero_cycles", cyc, 32'd0);
    check("zero_reads", reads, 32'd0);
    check("zero_valid_cycles", valid_cnt, 32'd0);

    expect_region(8'h10, 9'd4);
    base_addr = 8'h10; word_count = 9'd4; bus.out_ready = 1'b1; start_dump = 1'b1;
    step();
    k = 0;
    while (!bus.out_valid && k < 10) begin step(); k++; end
    check("abort_reached_send", {31'd0, bus.out_valid}, 32'd1);
    start_dump = 1'b0;
    step();
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_busy", {31'd0, dump_busy}, 32'd0);
    check("abort_no_handshake", words_done, 32'd0);
    exp_q.delete();
    run_dump(8'h20, 9'd2, -1, 0, cyc);
    check("restart_cycles", cyc, 32'd6);
    check("restart_first", {16'd0, rx[0]}, 32'h20DF);
    check("restart_first_addr", {24'd0, rd_addr[0]}, 32'h20);

    expect_region(8'h30, 9'd3);
    base_addr = 8'h30; word_count = 9'd3; bus.out_ready = 1'b1; start_dump = 1'b1;
    step(); step();
    check("pre_reset_busy", {31'd0, dump_busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("areset_mem_addr",      {24'd0, bus.mem_addr}, 32'd0);
    check("areset_mem_read",      {31'd0, bus.mem_read}, 32'd0);
    check("areset_out_data",      {16'd0, bus.out_data}, 32'd0);
    check("areset_out_valid",     {31'd0, bus.out_valid}, 32'd0);
    check("areset_out_last",      {31'd0, bus.out_last}, 32'd0);
    check("areset_dump_busy",     {31'd0, dump_busy}, 32'd0);
    check("areset_dump_complete", {31'd0, dump_complete}, 32'd0);
    exp_q.delete();
    start_dump = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("post_reset_idle_busy", {31'd0, dump_busy}, 32'd0);
    check("post_reset_idle_complete", {31'd0, dump_complete}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/program_dumper.md
# program_dumper

Streams a contiguous region of system RAM out over a valid/ready word interface after execution has halted. It is the read-side counterpart to `program_loader`: the system controller holds `start_dump` high while it owns the RAM port for unloading, and the dumper issues reads and presents each word downstream. It sits beside the CPU and loader on the shared memory mux. It drives only `mem_addr`/`mem_read` and never writes memory.

## Interface
- `WORD_SIZE`, 16, memory word width
- `MEM_ADDR_SIZE`, 8, RAM address width
- `clock` in 1: system clock, all state on rising edge
- `reset` in 1: asynchronous, active-high
- `start_dump` in 1: level request; held high for the whole dump; low aborts or acknowledges done
- `base_addr` in MEM_ADDR_SIZE: first address, sampled on IDLE→READ
- `word_count` in MEM_ADDR_SIZE+1: number of words (0..2^MEM_ADDR_SIZE), sampled on IDLE→READ
- `mem_addr` out MEM_ADDR_SIZE: RAM address
- `mem_read` out 1: RAM read enable
- `mem_read_data` in WORD_SIZE: RAM data, valid the cycle after `mem_read`
- `out_data` out WORD_SIZE: dumped word
- `out_valid` out 1: `out_data` valid
- `out_ready` in 1: downstream accepts when high with `out_valid`
- `out_last` out 1: high with `out_valid` on the final word
- `dump_busy` out 1: high in READ, CAPTURE, SEND
- `dump_complete` out 1: high in DONE

## Operation
- States: IDLE, READ, CAPTURE, SEND, DONE. All registers are reset to IDLE/0.
- IDLE:
  - If `start_dump` is high, latch `addr<=base_addr` and `remaining<=word_count`.
  - Then go to READ if `word_count!=0`, else go to DONE.
- READ: `mem_read=1`, `mem_addr=addr`; go to CAPTURE.
- CAPTURE: `out_data<=mem_read_data`; `out_last<=(remaining==1)`; go to SEND.
- SEND:
  - `out_valid=1`.
  - On `out_ready`: `remaining<=remaining-1` and `addr<=addr+1`, modulo 2^MEM_ADDR_SIZE so it wraps from max to 0.
  - Then go to DONE if `out_last`, else go to READ.
  - Without `out_ready`, stay in SEND with `out_data`/`out_last` stable.
- DONE: `dump_complete=1`; stay while `start_dump` is high; go to IDLE when it is low.
- Abort: `start_dump` low in READ, CAPTURE or SEND forces IDLE on the next edge.
  - `out_valid` drops, and no handshake is counted that cycle even if `out_ready` is high.
  - Abort is the only case besides reset where `out_valid` falls without acceptance.
- `mem_addr` is combinational from `addr`. It holds its last value outside READ.
- `mem_read` is 0 in every state except READ.
- `out_data` keeps its last captured value after transfer; it is 0 only after reset.
- `word_count=2^MEM_ADDR_SIZE` dumps all of RAM. Starting from `base_addr`, it wraps once and ends at `base_addr-1`.
- `word_count` bits above the `2^MEM_ADDR_SIZE` value are out of range. The dumper transfers the requested count mod 2^(MEM_ADDR_SIZE+1) without guarding.

## Timing
- Reset values: `mem_addr`=0, `mem_read`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `dump_busy`=0, `dump_complete`=0.
- `start_dump` is sampled high at edge E0. `mem_read` is high in cycle E0–E1. Data is captured at E2. `out_valid` is high from E2.
- Per word, with `out_ready` held high: 3 cycles (READ, CAPTURE, SEND). N words take 3N cycles from E0 to DONE.
- `dump_complete` rises the edge after the last handshake.
- Each extra cycle with `out_ready` low adds one cycle. No data is lost and no re-read occurs.
- `out_valid`/`out_data`/`out_last` are registered or decoded from state only. There is no combinational path from `out_ready` to `out_valid`.
- A reset assertion at any time returns to IDLE immediately, asynchronously, with all outputs at their reset values.
- After DONE→IDLE, a new dump may start on the very next edge where `start_dump` is high. The minimum low time is one cycle.

## Test plan
- Basic dump:
  - Stimulus: RAM[0x10..0x13]=0xA001..0xA004, `base_addr`=0x10, `word_count`=4, `out_ready`=1.
  - Required: 4 words in order, `out_last` only on 0xA004, `dump_complete` 12 cycles after start, `mem_read` pulses exactly 4 times.
- Backpressure:
  - Stimulus: same dump, `out_ready` low for 5 cycles on word 2.
  - Required: word 2 held stable with `out_valid` high, no extra `mem_read`, total 17 cycles.
- Wrap and full memory:
  - Stimulus: `base_addr`=0xFE, `word_count`=3.
  - Required: addresses 0xFE, 0xFF, 0x00.
  - Stimulus: `word_count`=256 from 0x00.
  - Required: 256 words, last from 0xFF.
- Zero count:
  - Stimulus: `word_count`=0.
  - Required: DONE one edge after start, `out_valid` and `mem_read` never asserted.
- Abort:
  - Stimulus: `start_dump` dropped while in SEND with `out_ready`=1.
  - Required: IDLE next edge, `out_valid`=0, no handshake counted. A restart with `base_addr`=0x20 dumps from 0x20 cleanly.
- Async reset:
  - Stimulus: `reset` pulsed mid-CAPTURE between edges.
  - Required: all outputs at reset values before the next edge, then IDLE.
